// File: rtl/p405s_br_hist_table.sv
// p405s_br_hist_table: dynamic branch predictor built from a table of saturating counters.
// Ports: CB/reset (sync, active-high); lkp* decode-stage lookup request (index, BD sign, hold);
//        upd* exe-stage resolution (index, outcome, mispredict); pred* registered prediction;
//        initBusy high while the post-reset table sweep runs; mispredCnt saturating statistic.
module p405s_br_hist_table #(
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1,
  parameter int STAT_W   = 16
) (
  input  logic              CB,
  input  logic              reset,
  input  logic              lkpValid,
  input  logic [IDX_W-1:0]  lkpIdx,
  input  logic              lkpBD_0,
  input  logic              lkpHold,
  input  logic              updValid,
  input  logic [IDX_W-1:0]  updIdx,
  input  logic              updTaken,
  input  logic              updMispred,
  output logic              predValid,
  output logic              predTaken,
  output logic              predStrong,
  output logic              initBusy,
  output logic [STAT_W-1:0] mispredCnt
);
  localparam int DEPTH = 1 << IDX_W;
  typedef enum logic {INIT, RUN} state_e;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic [CNT_W-1:0]  upd_cur, upd_nxt, rd_cnt;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic              pred_strong_q, pred_strong_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic              run, lkp_new;
  assign run = state_q == RUN;
  always_comb begin
    upd_cur = cnt_q[updIdx];
    upd_nxt = updTaken ? (&upd_cur ? upd_cur : upd_cur + 1'b1) : (|upd_cur ? upd_cur - 1'b1 : upd_cur);
    cnt_d = cnt_q;
    if (!run) cnt_d[init_ptr_q] = CNT_W'(INIT_CNT);
    else if (updValid) cnt_d[updIdx] = upd_nxt;
    // reading the next-state table gives the write-first bypass for same-index update
    rd_cnt = cnt_d[lkpIdx];
    lkp_new = lkpValid && !lkpHold;
    state_d = (!run && &init_ptr_q) ? RUN : state_q;
    init_ptr_d = run ? init_ptr_q : init_ptr_q + 1'b1;
    pred_valid_d = lkpHold ? pred_valid_q : lkpValid;
    // during the sweep the table is not trusted: fall back to backward-taken/forward-not-taken
    pred_taken_d = !lkp_new ? pred_taken_q : run ? rd_cnt[CNT_W-1] : lkpBD_0;
    pred_strong_d = !lkp_new ? pred_strong_q : run && (rd_cnt == '0 || &rd_cnt);
    mispred_cnt_d = mispred_cnt_q + STAT_W'(updValid && updMispred && !(&mispred_cnt_q));
  end
  always_ff @(posedge CB) begin
    if (reset) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_strong_q <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_strong_q <= pred_strong_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
  // table needs no reset: the sweep rewrites every entry before it is used
  always_ff @(posedge CB) begin
    if (!reset) cnt_q <= cnt_d;
  end
  assign predValid  = pred_valid_q;
  assign predTaken  = pred_taken_q;
  assign predStrong = pred_strong_q;
  assign initBusy   = state_q == INIT;
  assign mispredCnt = mispred_cnt_q;
endmodule

// File: tb/tb_p405s_br_hist_table.sv
// tb_p405s_br_hist_table: scoreboard bench with a behavioural predictor model.
module tb_p405s_br_hist_table;
  localparam int IDX_W = 6;
  localparam int STAT_W = 4;
  localparam int DEPTH = 64;
  localparam int CMAX = 3;
  localparam int SMAX = 15;
  logic CB = 1'b0;
  logic reset, lkpValid, lkpBD_0, lkpHold, updValid, updTaken, updMispred;
  logic [IDX_W-1:0] lkpIdx, updIdx;
  logic predValid, predTaken, predStrong, initBusy;
  logic [STAT_W-1:0] mispredCnt;
  always #5 CB = ~CB;
  p405s_br_hist_table #(.IDX_W(IDX_W), .CNT_W(2), .INIT_CNT(1), .STAT_W(STAT_W)) dut (
    .CB(CB), .reset(reset), .lkpValid(lkpValid), .lkpIdx(lkpIdx), .lkpBD_0(lkpBD_0),
    .lkpHold(lkpHold), .updValid(updValid), .updIdx(updIdx), .updTaken(updTaken),
    .updMispred(updMispred), .predValid(predValid), .predTaken(predTaken),
    .predStrong(predStrong), .initBusy(initBusy), .mispredCnt(mispredCnt)
  );
  typedef struct {
    bit pv, pt, ps, busy;
    int mc;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int tbl[DEPTH];
  bit m_init = 1'b1;
  int m_ptr = 0;
  bit m_pv = 1'b0, m_pt = 1'b0, m_ps = 1'b0;
  int m_mc = 0;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction
  task automatic drive(input bit rst, input bit lv, input int li, input bit bd, input bit hold,
                       input bit uv, input int ui, input bit ut, input bit um);
    bit was_init;
    int c;
    reset = rst; lkpValid = lv; lkpIdx = li[IDX_W-1:0]; lkpBD_0 = bd; lkpHold = hold;
    updValid = uv; updIdx = ui[IDX_W-1:0]; updTaken = ut; updMispred = um;
    if (rst) begin
      m_init = 1'b1; m_ptr = 0; m_pv = 1'b0; m_pt = 1'b0; m_ps = 1'b0; m_mc = 0;
    end else begin
      was_init = m_init;
      if (was_init) begin
        tbl[m_ptr] = 1;
        m_ptr++;
        if (m_ptr == DEPTH) m_init = 1'b0;
      end else if (uv) begin
        tbl[ui] = ut ? ((tbl[ui] < CMAX) ? tbl[ui] + 1 : CMAX) : ((tbl[ui] > 0) ? tbl[ui] - 1 : 0);
      end
      if (uv && um && m_mc < SMAX) m_mc++;
      if (!hold) begin
        m_pv = lv;
        if (lv) begin
          c = tbl[li];
          m_pt = was_init ? bd : (c >= 2);
          m_ps = !was_init && (c == 0 || c == CMAX);
        end
      end
    end
    sb.push_back('{pv: m_pv, pt: m_pt, ps: m_ps, busy: m_init, mc: m_mc});
    @(posedge CB);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge CB) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("predValid", 32'(predValid), 32'(e.pv));
      chk("predTaken", 32'(predTaken), 32'(e.pt));
      chk("predStrong", 32'(predStrong), 32'(e.ps));
      chk("initBusy", 32'(initBusy), 32'(e.busy));
      chk("mispredCnt", 32'(mispredCnt), 32'(e.mc));
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 1, 3, 1, 0);
    drive(0, 1, 3, 0, 0, 1, 3, 1, 0);
    idle(61);
    drive(0, 1, 63, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 5, 1, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 1, 5, 0, 1);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 0, 0, 1, 9, 1, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 1, 1, 1, 5, 1, 0);
    drive(0, 0, 12, 0, 1, 1, 5, 1, 0);
    drive(0, 1, 9, 0, 1, 1, 5, 1, 0);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) drive(0, 0, 0, 0, 0, 1, 7, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(30);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(66);
    repeat (3000) begin
      drive($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3) == 0);
    end
    @(negedge CB);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
